pe_noc_endpoint: RTL

PE-side endpoint of the memory↔PE NoC packet protocol. It receives 64-bit packets from the memory controller, decodes the kernel-row (filter) and ifmap-row payloads into per-type holding registers for the PE datapath, and packetizes the PE's output spikes and end-of-timestep DONE tokens into output-type packets addressed back to the memory interface. One instance sits between each PE (addresses 0001/0101/0011/0111/1100) and its NoC router port.

---
 rtl/noc_pkg.sv | 39 +++
 rtl/pe_tx_fifo.sv | 51 +++++
 rtl/pe_noc_endpoint.sv | 127 ++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions for the PE endpoints: addresses, packet type codes,
// field positions and the outbound packet builder.
package noc_pkg;

    localparam logic [3:0] ADDR_PE1 = 4'b0001;
    localparam logic [3:0] ADDR_PE2 = 4'b0101;
    localparam logic [3:0] ADDR_PE3 = 4'b0011;
    localparam logic [3:0] ADDR_PE4 = 4'b0111;
    localparam logic [3:0] ADDR_PE5 = 4'b1100;
    localparam logic [3:0] ADDR_MEM = 4'b0000;

    typedef enum logic [1:0] {
        PKT_INPUT  = 2'b00,
        PKT_KERNEL = 2'b01,
        PKT_RSVD   = 2'b10,
        PKT_OUTPUT = 2'b11
    } pkt_type_e;

    localparam int DST_LSB       = 60;
    localparam int SRC_LSB       = 56;
    localparam int TYPE_LSB      = 54;
    localparam int OUT_PAYLOAD_W = 10;

    localparam logic [9:0] DONE_CODE = 10'h3FF;
    localparam logic [4:0] MAX_COORD = 5'd20;

    function automatic logic [63:0] make_out_pkt(input logic [3:0] dst,
                                                 input logic [3:0] src,
                                                 input logic [9:0] payload);
        logic [63:0] pkt;
        pkt                         = '0;
        pkt[DST_LSB +: 4]           = dst;
        pkt[SRC_LSB +: 4]           = src;
        pkt[TYPE_LSB +: 2]          = PKT_OUTPUT;
        pkt[OUT_PAYLOAD_W-1:0]      = payload;
        return pkt;
    endfunction

endpackage

// File: rtl/pe_tx_fifo.sv
// Small synchronous FIFO holding outbound spike/DONE payloads.
// Head entry is presented combinationally on o_data.
module pe_tx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Full is judged on the registered count, so a same-cycle pop never makes room.
    assign w_wr = i_push & ~o_full;
    assign w_rd = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/pe_noc_endpoint.sv
// PE-side NoC endpoint: decodes inbound kernel/ifmap packets into holding
// registers and packetizes output spikes and DONE tokens toward memory.
module pe_noc_endpoint
    import noc_pkg::*;
#(
    parameter logic [3:0] PE_ADDR        = ADDR_PE1,
    parameter logic [3:0] MEM_ADDR       = ADDR_MEM,
    parameter int         WIDTH_NOC      = 64,
    parameter int         FILTER_WIDTH   = 40,
    parameter int         IFMAP_WIDTH    = 25,
    parameter int         OUT_FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [WIDTH_NOC-1:0]    rx_data,
    output logic                    filt_valid,
    input  logic                    filt_ready,
    output logic [FILTER_WIDTH-1:0] filt_data,
    output logic                    ifmap_valid,
    input  logic                    ifmap_ready,
    output logic [IFMAP_WIDTH-1:0]  ifmap_data,
    input  logic                    spike_valid,
    output logic                    spike_ready,
    input  logic [4:0]              spike_x,
    input  logic [4:0]              spike_y,
    input  logic                    done_valid,
    output logic                    done_ready,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [WIDTH_NOC-1:0]    tx_data,
    output logic                    err_drop
);
    logic [3:0]                    w_dst;
    pkt_type_e                     w_type;
    logic                          w_rx_drop;
    logic                          w_rx_ready;
    logic                          w_rx_fire;
    logic                          w_unused_bits;
    logic                          r_filt_valid;
    logic [FILTER_WIDTH-1:0]       r_filt_data;
    logic                          r_ifmap_valid;
    logic [IFMAP_WIDTH-1:0]        r_ifmap_data;
    logic                          r_err_drop;
    logic                          w_spike_bad;
    logic                          w_spike_fire;
    logic                          w_done_fire;
    logic                          w_push;
    logic [OUT_PAYLOAD_W-1:0]      w_push_data;
    logic [OUT_PAYLOAD_W-1:0]      w_head;
    logic                          w_fifo_full;
    logic                          w_fifo_empty;
    logic [$clog2(OUT_FIFO_DEPTH):0] w_fifo_count;

    assign w_dst         = rx_data[DST_LSB +: 4];
    assign w_type        = pkt_type_e'(rx_data[TYPE_LSB +: 2]);
    assign w_unused_bits = ^{rx_data[SRC_LSB +: 4], rx_data[TYPE_LSB-1:FILTER_WIDTH]};
    assign w_rx_drop     = (w_dst != PE_ADDR) || (w_type == PKT_OUTPUT) || (w_type == PKT_RSVD);

    // A holding register about to be consumed can take the next packet in the same cycle.
    always_comb begin
        w_rx_ready = 1'b0;
        if (w_rx_drop)                 w_rx_ready = 1'b1;
        else if (w_type == PKT_KERNEL) w_rx_ready = ~r_filt_valid | filt_ready;
        else                           w_rx_ready = ~r_ifmap_valid | ifmap_ready;
    end

    assign rx_ready  = rst_n & w_rx_ready;
    assign w_rx_fire = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt_valid  <= 1'b0;
            r_filt_data   <= '0;
            r_ifmap_valid <= 1'b0;
            r_ifmap_data  <= '0;
            r_err_drop    <= 1'b0;
        end else begin
            if (r_filt_valid & filt_ready)   r_filt_valid  <= 1'b0;
            if (r_ifmap_valid & ifmap_ready) r_ifmap_valid <= 1'b0;
            if (w_rx_fire & ~w_rx_drop & (w_type == PKT_KERNEL)) begin
                r_filt_valid <= 1'b1;
                r_filt_data  <= rx_data[FILTER_WIDTH-1:0];
            end
            if (w_rx_fire & ~w_rx_drop & (w_type == PKT_INPUT)) begin
                r_ifmap_valid <= 1'b1;
                r_ifmap_data  <= rx_data[IFMAP_WIDTH-1:0];
            end
            r_err_drop <= (w_rx_fire & w_rx_drop) | (w_spike_fire & w_spike_bad);
        end
    end

    assign filt_valid  = r_filt_valid;
    assign filt_data   = r_filt_data;
    assign ifmap_valid = r_ifmap_valid;
    assign ifmap_data  = r_ifmap_data;
    assign err_drop    = r_err_drop;

    // Out-of-range coordinates are swallowed so no spike payload can alias DONE_CODE.
    assign w_spike_bad  = (spike_x > MAX_COORD) || (spike_y > MAX_COORD);
    assign spike_ready  = rst_n & ~w_fifo_full;
    assign done_ready   = rst_n & ~w_fifo_full & ~spike_valid;
    assign w_spike_fire = spike_valid & spike_ready;
    assign w_done_fire  = done_valid & done_ready;
    assign w_push       = (w_spike_fire & ~w_spike_bad) | w_done_fire;
    assign w_push_data  = w_spike_fire ? {spike_x, spike_y} : DONE_CODE;

    pe_tx_fifo #(
        .WIDTH (OUT_PAYLOAD_W),
        .DEPTH (OUT_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  (w_push_data),
        .i_pop   (tx_valid & tx_ready),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign tx_valid = (w_fifo_count != '0);
    assign tx_data  = w_fifo_empty ? '0 : make_out_pkt(MEM_ADDR, PE_ADDR, w_head);

endmodule
